// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR key controller: FSM state encoding,
// key action codes and the NEC remote command bytes.
package ir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_CLR  = 4'd10;
    localparam logic [3:0] KEY_BS   = 4'd11;
    localparam logic [3:0] KEY_ENT  = 4'd12;
    localparam logic [3:0] KEY_NONE = 4'd15;

    localparam logic [7:0] CMD_0   = 8'h16;
    localparam logic [7:0] CMD_1   = 8'h0C;
    localparam logic [7:0] CMD_2   = 8'h18;
    localparam logic [7:0] CMD_3   = 8'h5E;
    localparam logic [7:0] CMD_4   = 8'h08;
    localparam logic [7:0] CMD_5   = 8'h1C;
    localparam logic [7:0] CMD_6   = 8'h5A;
    localparam logic [7:0] CMD_7   = 8'h42;
    localparam logic [7:0] CMD_8   = 8'h52;
    localparam logic [7:0] CMD_9   = 8'h4A;
    localparam logic [7:0] CMD_CLR = 8'h45;
    localparam logic [7:0] CMD_BS  = 8'h44;
    localparam logic [7:0] CMD_ENT = 8'h40;

    // Key codes 0..9 are plain digit entries
    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/ir_key_map.sv
// Combinational NEC command byte to key code lookup.
// Unmapped command bytes report valid_o = 0 and KEY_NONE.
module ir_key_map (
    input  logic [7:0] cmd_i,
    output logic       valid_o,
    output logic [3:0] key_o
);
    import ir_pkg::*;

    // Translate the remote's command byte into a key action code
    always_comb begin
        valid_o = 1'b1;
        key_o   = KEY_NONE;
        case (cmd_i)
            CMD_0:   key_o = 4'd0;
            CMD_1:   key_o = 4'd1;
            CMD_2:   key_o = 4'd2;
            CMD_3:   key_o = 4'd3;
            CMD_4:   key_o = 4'd4;
            CMD_5:   key_o = 4'd5;
            CMD_6:   key_o = 4'd6;
            CMD_7:   key_o = 4'd7;
            CMD_8:   key_o = 4'd8;
            CMD_9:   key_o = 4'd9;
            CMD_CLR: key_o = KEY_CLR;
            CMD_BS:  key_o = KEY_BS;
            CMD_ENT: key_o = KEY_ENT;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ir_key_ctrl.sv
// NEC IR command controller: validates decoded frames, runs digit entry,
// clear, backspace and enter on a 6-digit BCD edit buffer, and handles
// hold/auto-repeat with a millisecond timeout.
// Optional build macro IR_ADDR_FILTER_EN: when defined, frames must also
// carry address ADDR with a correct address complement byte.
module ir_key_ctrl #(
    parameter logic [7:0] ADDR            = 8'h00,
    parameter int         TICK_DIV        = 50000,
    parameter int         HOLD_TIMEOUT_MS = 120,
    parameter int         RPT_START       = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_frame,
    input  logic        i_frame_vld,
    input  logic        i_repeat,
    output logic [23:0] o_digits,
    output logic [23:0] o_value,
    output logic        o_commit,
    output logic [3:0]  o_key,
    output logic        o_key_vld,
    output logic [5:0]  o_dp,
    output logic [7:0]  o_err_cnt
);
    import ir_pkg::*;

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TO_W   = $clog2(HOLD_TIMEOUT_MS + 1);
    localparam int RPT_W  = (RPT_START > 0) ? $clog2(RPT_START + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(HOLD_TIMEOUT_MS);
    localparam logic [RPT_W-1:0]  RPT_MAX  = RPT_W'(RPT_START);

    state_t            state_q, state_d;
    logic [31:0]       frame_q, frame_d;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [TO_W-1:0]   to_q, to_d;
    logic [RPT_W-1:0]  rpt_q, rpt_d;
    logic [23:0]       digits_q, digits_d;
    logic [23:0]       value_q, value_d;
    logic [3:0]        key_q, key_d;
    logic              key_vld_q, key_vld_d;
    logic              commit_q, commit_d;
    logic [5:0]        dp_q, dp_d;
    logic [7:0]        err_q, err_d;

    logic              tick;
    logic              map_vld;
    logic [3:0]        map_key;
    logic              cmd_ok;
    logic              addr_ok;
    logic              pass;
    logic              auto_ok;
    logic [RPT_W-1:0]  rpt_inc;
    logic [TO_W-1:0]   to_nxt;
    logic [1:0]        err_inc;
    logic [8:0]        err_sum;

    ir_key_map u_key_map (
        .cmd_i   (frame_q[15:8]),
        .valid_o (map_vld),
        .key_o   (map_key)
    );

    assign tick    = (tick_cnt_q == TICK_MAX);
    assign cmd_ok  = map_vld && (frame_q[15:8] == ~frame_q[7:0]);
    assign pass    = cmd_ok && addr_ok;
    assign auto_ok = is_digit(map_key) || (map_key == KEY_BS);
    assign rpt_inc = (rpt_q == RPT_MAX) ? rpt_q : rpt_q + RPT_W'(1);
    assign to_nxt  = to_q + TO_W'(1);

`ifdef IR_ADDR_FILTER_EN
    assign addr_ok = (frame_q[31:24] == ADDR) && (frame_q[31:24] == ~frame_q[23:16]);
`else
    logic unused_addr;
    assign addr_ok     = 1'b1;
    assign unused_addr = ^{frame_q[31:16], ADDR};
`endif

    // Free-running millisecond prescaler, independent of the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    // Next-state, key action and error accounting for the key FSM
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        to_d      = to_q;
        rpt_d     = rpt_q;
        digits_d  = digits_q;
        value_d   = value_q;
        key_d     = key_q;
        key_vld_d = 1'b0;
        commit_d  = 1'b0;
        err_inc   = 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (i_frame_vld) begin
                    frame_d = i_frame;
                    rpt_d   = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (i_frame_vld) begin
                    err_inc = err_inc + 2'd1;
                end
                if (pass) begin
                    state_d = ST_EXEC;
                end else begin
                    err_inc = err_inc + 2'd1;
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (i_frame_vld) begin
                    err_inc = 2'd1;
                end
                if (is_digit(map_key)) begin
                    digits_d = {digits_q[19:0], map_key};
                end else if (map_key == KEY_CLR) begin
                    digits_d = '0;
                end else if (map_key == KEY_BS) begin
                    digits_d = {4'h0, digits_q[23:4]};
                end else if (map_key == KEY_ENT) begin
                    value_d  = digits_q;
                    commit_d = 1'b1;
                end
                key_d     = map_key;
                key_vld_d = 1'b1;
                to_d      = '0;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_frame_vld) begin
                    frame_d = i_frame;
                    rpt_d   = '0;
                    to_d    = '0;
                    state_d = ST_CHECK;
                end else if (i_repeat) begin
                    to_d  = '0;
                    rpt_d = rpt_inc;
                    if ((rpt_inc >= RPT_MAX) && auto_ok) begin
                        state_d = ST_EXEC;
                    end
                end else if (tick) begin
                    if (to_nxt >= TO_MAX) begin
                        to_d    = '0;
                        state_d = ST_IDLE;
                    end else begin
                        to_d = to_nxt;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        err_sum = {1'b0, err_q} + {7'b0, err_inc};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
        dp_d    = (digits_d != value_d) ? 6'b000001 : 6'b000000;
    end

    // State and output registers; reset drops any partially received frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            to_q      <= '0;
            rpt_q     <= '0;
            digits_q  <= '0;
            value_q   <= '0;
            key_q     <= KEY_NONE;
            key_vld_q <= 1'b0;
            commit_q  <= 1'b0;
            dp_q      <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            to_q      <= to_d;
            rpt_q     <= rpt_d;
            digits_q  <= digits_d;
            value_q   <= value_d;
            key_q     <= key_d;
            key_vld_q <= key_vld_d;
            commit_q  <= commit_d;
            dp_q      <= dp_d;
            err_q     <= err_d;
        end
    end

    assign o_digits  = digits_q;
    assign o_value   = value_q;
    assign o_commit  = commit_q;
    assign o_key     = key_q;
    assign o_key_vld = key_vld_q;
    assign o_dp      = dp_q;
    assign o_err_cnt = err_q;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Self-checking bench for ir_key_ctrl with a scaled-down ms tick
// (TICK_DIV = 50). Expected key actions go into a scoreboard queue when the
// stimulus is driven and are popped when the DUT pulses o_key_vld.
module tb_ir_key_ctrl;

    localparam int TICK_DIV  = 50;
    localparam int HOLD_MS   = 120;
    localparam int RPT_START = 3;
    localparam int MS        = TICK_DIV;
`ifdef IR_ADDR_FILTER_EN
    localparam int ADDR_ERR = 1;
`else
    localparam int ADDR_ERR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_frame = '0;
    logic        i_frame_vld = 1'b0;
    logic        i_repeat = 1'b0;
    logic [23:0] o_digits;
    logic [23:0] o_value;
    logic        o_commit;
    logic [3:0]  o_key;
    logic        o_key_vld;
    logic [5:0]  o_dp;
    logic [7:0]  o_err_cnt;

    int checks = 0;
    int errors = 0;
    int cycleNo = 0;

    typedef struct {
        logic [3:0]  key;
        logic [23:0] digits;
        logic [23:0] value;
        logic        commit;
        int          cycle;
    } exp_t;

    typedef struct {
        logic [31:0] frame;
        bit          accept;
        logic [3:0]  key;
        logic [23:0] digits;
        logic [23:0] value;
        logic [5:0]  dp;
        logic [7:0]  err;
    } vec_t;

    exp_t expQ[$];
    exp_t mon;
    vec_t vecs[14];
    logic [23:0] dModel;

    ir_key_ctrl #(
        .ADDR            (8'h00),
        .TICK_DIV        (TICK_DIV),
        .HOLD_TIMEOUT_MS (HOLD_MS),
        .RPT_START       (RPT_START)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_frame     (i_frame),
        .i_frame_vld (i_frame_vld),
        .i_repeat    (i_repeat),
        .o_digits    (o_digits),
        .o_value     (o_value),
        .o_commit    (o_commit),
        .o_key       (o_key),
        .o_key_vld   (o_key_vld),
        .o_dp        (o_dp),
        .o_err_cnt   (o_err_cnt)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cycleNo <= cycleNo + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drives one strobe cycle starting at a falling edge. A frame strobe is
    // sampled at the next rising edge t; the action lands at edge t+2, which
    // is the first value an observer sampling at edge t+3 sees. A repeat in
    // HOLD skips CHECK and lands one edge earlier.
    task automatic applyStimulus(input bit vld, input logic [31:0] frame, input bit rpt,
                                 input bit expKey, input logic [3:0] key,
                                 input logic [23:0] digits, input logic [23:0] value,
                                 input bit commit);
        exp_t e;
        if (expKey) begin
            e.key    = key;
            e.digits = digits;
            e.value  = value;
            e.commit = commit;
            e.cycle  = cycleNo + (vld ? 3 : 2);
            expQ.push_back(e);
        end
        i_frame_vld = vld;
        i_frame     = frame;
        i_repeat    = rpt;
        @(negedge clk);
        i_frame_vld = 1'b0;
        i_repeat    = 1'b0;
    endtask

    // Scoreboard consumer: every key pulse must match the oldest expectation
    always @(negedge clk) begin
        if (o_key_vld) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_key_vld actual=1 required=0 (key %0d)", o_key);
            end else begin
                mon = expQ.pop_front();
                checkOutput("sb_key", 32'(o_key), 32'(mon.key));
                checkOutput("sb_digits", 32'(o_digits), 32'(mon.digits));
                checkOutput("sb_value", 32'(o_value), 32'(mon.value));
                checkOutput("sb_commit", 32'(o_commit), 32'(mon.commit));
                checkOutput("sb_latency_cycle", 32'(cycleNo), 32'(mon.cycle));
            end
        end else if (o_commit) begin
            checks++;
            errors++;
            $display("[TB] FAIL commit_without_key_vld actual=1 required=0");
        end
    end

    initial begin
        vecs[0]  = '{32'h00FF0CF3, 1'b1, 4'd1,  24'h000001, 24'h000000, 6'd1, 8'd0};
        vecs[1]  = '{32'h00FF18E7, 1'b1, 4'd2,  24'h000012, 24'h000000, 6'd1, 8'd0};
        vecs[2]  = '{32'h00FF40BF, 1'b1, 4'd12, 24'h000012, 24'h000012, 6'd0, 8'd0};
        vecs[3]  = '{32'h00FF0CF2, 1'b0, 4'd0,  24'h000012, 24'h000012, 6'd0, 8'd1};
`ifdef IR_ADDR_FILTER_EN
        vecs[4]  = '{32'h01FE0CF3, 1'b0, 4'd0,  24'h000012, 24'h000012, 6'd0, 8'd2};
`else
        vecs[4]  = '{32'h01FE0CF3, 1'b1, 4'd1,  24'h000121, 24'h000012, 6'd1, 8'd1};
`endif
        vecs[5]  = '{32'h00FF45BA, 1'b1, 4'd10, 24'h000000, 24'h000012, 6'd1, 8'(1 + ADDR_ERR)};
        vecs[6]  = '{32'h00FF0CF3, 1'b1, 4'd1,  24'h000001, 24'h000012, 6'd1, 8'(1 + ADDR_ERR)};
        vecs[7]  = '{32'h00FF18E7, 1'b1, 4'd2,  24'h000012, 24'h000012, 6'd0, 8'(1 + ADDR_ERR)};
        vecs[8]  = '{32'h00FF5EA1, 1'b1, 4'd3,  24'h000123, 24'h000012, 6'd1, 8'(1 + ADDR_ERR)};
        vecs[9]  = '{32'h00FF08F7, 1'b1, 4'd4,  24'h001234, 24'h000012, 6'd1, 8'(1 + ADDR_ERR)};
        vecs[10] = '{32'h00FF1CE3, 1'b1, 4'd5,  24'h012345, 24'h000012, 6'd1, 8'(1 + ADDR_ERR)};
        vecs[11] = '{32'h00FF5AA5, 1'b1, 4'd6,  24'h123456, 24'h000012, 6'd1, 8'(1 + ADDR_ERR)};
        vecs[12] = '{32'h00FF42BD, 1'b1, 4'd7,  24'h234567, 24'h000012, 6'd1, 8'(1 + ADDR_ERR)};
        vecs[13] = '{32'h00FF44BB, 1'b1, 4'd11, 24'h023456, 24'h000012, 6'd1, 8'(1 + ADDR_ERR)};

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_digits", 32'(o_digits), 32'h0);
        checkOutput("rst_value", 32'(o_value), 32'h0);
        checkOutput("rst_key", 32'(o_key), 32'hF);
        checkOutput("rst_key_vld", 32'(o_key_vld), 32'h0);
        checkOutput("rst_commit", 32'(o_commit), 32'h0);
        checkOutput("rst_dp", 32'(o_dp), 32'h0);
        checkOutput("rst_err", 32'(o_err_cnt), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven frames: entry, enter, bad complement, address, CLR, wrap, BS
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, vecs[i].frame, 1'b0, vecs[i].accept, vecs[i].key,
                          vecs[i].digits, vecs[i].value, vecs[i].key == 4'd12);
            repeat (6) @(negedge clk);
            checkOutput($sformatf("vec%0d_digits", i), 32'(o_digits), 32'(vecs[i].digits));
            checkOutput($sformatf("vec%0d_value", i), 32'(o_value), 32'(vecs[i].value));
            checkOutput($sformatf("vec%0d_dp", i), 32'(o_dp), 32'(vecs[i].dp));
            checkOutput($sformatf("vec%0d_err", i), 32'(o_err_cnt), 32'(vecs[i].err));
            checkOutput($sformatf("vec%0d_pending", i), 32'(expQ.size()), 32'h0);
        end

        // Held BS: repeats 108 ms apart, auto-repeat from the third one
        dModel = 24'h023456;
        for (int i = 1; i <= 5; i++) begin
            repeat (108 * MS) @(negedge clk);
            if (i >= RPT_START) dModel = {4'h0, dModel[23:4]};
            applyStimulus(1'b0, 32'h0, 1'b1, i >= RPT_START, 4'd11, dModel, 24'h000012, 1'b0);
        end
        repeat (6) @(negedge clk);
        checkOutput("bs_hold_digits", 32'(o_digits), 32'h000023);
        checkOutput("bs_hold_pending", 32'(expQ.size()), 32'h0);

        // Past the hold timeout a repeat must do nothing
        repeat (122 * MS) @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 24'h0, 24'h0, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("timeout_digits", 32'(o_digits), 32'h000023);

        // Frame strobe arriving while the previous frame is in CHECK is dropped
        applyStimulus(1'b1, 32'h00FF5EA1, 1'b0, 1'b1, 4'd3, 24'h000233, 24'h000012, 1'b0);
        applyStimulus(1'b1, 32'h00FF08F7, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("drop_digits", 32'(o_digits), 32'h000233);
        checkOutput("drop_err", 32'(o_err_cnt), 32'(2 + ADDR_ERR));

        // Bad frame plus a strobe during its CHECK counts two errors
        applyStimulus(1'b1, 32'h00FF0CF2, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0, 1'b0);
        applyStimulus(1'b1, 32'h00FF0CF3, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("bad_drop_digits", 32'(o_digits), 32'h000233);
        checkOutput("bad_drop_err", 32'(o_err_cnt), 32'(4 + ADDR_ERR));

        // Held CLR never auto-repeats
        applyStimulus(1'b1, 32'h00FF45BA, 1'b0, 1'b1, 4'd10, 24'h0, 24'h000012, 1'b0);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 24'h0, 24'h0, 1'b0);
            repeat (10) @(negedge clk);
        end
        checkOutput("clr_hold_digits", 32'(o_digits), 32'h0);
        checkOutput("clr_hold_pending", 32'(expQ.size()), 32'h0);

        // Digit auto-repeat, then frame+repeat together: frame wins, count restarts
        applyStimulus(1'b1, 32'h00FF1CE3, 1'b0, 1'b1, 4'd5, 24'h000005, 24'h000012, 1'b0);
        repeat (6) @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, i == 3, 4'd5, 24'h000055, 24'h000012, 1'b0);
            repeat (10) @(negedge clk);
        end
        applyStimulus(1'b1, 32'h00FF5AA5, 1'b1, 1'b1, 4'd6, 24'h000556, 24'h000012, 1'b0);
        repeat (6) @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 24'h0, 24'h0, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("simul_digits", 32'(o_digits), 32'h000556);
        checkOutput("simul_dp", 32'(o_dp), 32'h1);
        checkOutput("simul_pending", 32'(expQ.size()), 32'h0);
        applyStimulus(1'b1, 32'h00FF40BF, 1'b0, 1'b1, 4'd12, 24'h000556, 24'h000556, 1'b1);
        repeat (6) @(negedge clk);
        checkOutput("ent2_value", 32'(o_value), 32'h000556);
        checkOutput("ent2_dp", 32'(o_dp), 32'h0);
        checkOutput("ent2_key", 32'(o_key), 32'd12);

        // Error counter saturates at 255
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b1, 32'h00FF0CF2, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0, 1'b0);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checkOutput("err_saturate", 32'(o_err_cnt), 32'd255);

        // Reset in the middle of a frame: all outputs cleared, frame forgotten
        applyStimulus(1'b1, 32'h00FF0CF3, 1'b0, 1'b0, 4'd0, 24'h0, 24'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_digits", 32'(o_digits), 32'h0);
        checkOutput("midrst_value", 32'(o_value), 32'h0);
        checkOutput("midrst_key", 32'(o_key), 32'hF);
        checkOutput("midrst_dp", 32'(o_dp), 32'h0);
        checkOutput("midrst_err", 32'(o_err_cnt), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("postrst_digits", 32'(o_digits), 32'h0);
        checkOutput("postrst_key", 32'(o_key), 32'hF);
        checkOutput("postrst_pending", 32'(expQ.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_key_ctrl.md
Name: ir_key_ctrl

Overview:
Command controller between the NEC IR receiver and the 6-digit FND display path. It validates each decoded 32-bit frame and maps the command byte to key actions: digit entry, clear, backspace and enter. It also handles hold/repeat codes with a millisecond timeout, and maintains a 6-digit BCD edit buffer plus a committed value for the display mux.

Parameters:
ADDR, 8'h00, expected custom/address byte (used only with IR_ADDR_FILTER_EN)
TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clk)
HOLD_TIMEOUT_MS, 120, ms without a repeat code before leaving HOLD
RPT_START, 3, repeat codes ignored before auto-repeat begins

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  reset, asynchronous, active-low
i_frame  input  32  decoded frame: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd
i_frame_vld  input  1  one-cycle strobe, i_frame valid
i_repeat  input  1  one-cycle strobe, NEC repeat code received
o_digits  output  24  edit buffer, 6 BCD nibbles, [3:0] = rightmost digit
o_value  output  24  committed value, 6 BCD nibbles
o_commit  output  1  one-cycle pulse when o_value is loaded
o_key  output  4  last key code: 0-9 digits, 10 CLR, 11 BS, 12 ENT, 15 none
o_key_vld  output  1  one-cycle pulse per executed key action
o_dp  output  6  decimal points: 6'b000001 while o_digits != o_value, else 0
o_err_cnt  output  8  rejected/dropped frame count, saturates at 255

Behaviour:
- Reset values: o_digits, o_value = 0; o_commit, o_key_vld = 0; o_key = 4'hF; o_dp = 0; o_err_cnt = 0; state IDLE; tick and timeout counters = 0.
- Cmd map: 0x16→0, 0x0C→1, 0x18→2, 0x5E→3, 0x08→4, 0x1C→5, 0x5A→6, 0x42→7, 0x52→8, 0x4A→9, 0x45→CLR, 0x44→BS, 0x40→ENT. Any other cmd is invalid.
- FSM states: IDLE, CHECK, EXEC, HOLD.
- IDLE: on i_frame_vld, register i_frame and go to CHECK.
- CHECK:
  - Pass requires cmd == ~cmdb and cmd is mapped.
  - Pass → EXEC. Fail → o_err_cnt+1 and return to IDLE.
- EXEC: perform the action for one cycle, then go to HOLD with the timeout counter cleared.
  - Registered outputs update at the clock edge ending EXEC.
  - Latency: strobe sampled at edge t; o_key_vld and the new o_digits are visible from edge t+3.
- Actions:
  - Digit: o_digits = {o_digits[19:0], d}; the digit shifted out is lost.
  - CLR: o_digits = 0.
  - BS: o_digits = {4'h0, o_digits[23:4]}.
  - ENT: o_value = o_digits and o_commit pulses in the same cycle as o_key_vld.
- HOLD:
  - The ms tick increments the timeout counter.
  - Timeout reaching HOLD_TIMEOUT_MS → IDLE.
  - i_repeat clears the timeout and increments the repeat count.
  - Once the repeat count ≥ RPT_START and the held key is BS or a digit, each further repeat re-executes the action through EXEC. CLR and ENT never auto-repeat.
  - i_frame_vld in HOLD is handled exactly as in IDLE (new key; repeat count cleared).
- Simultaneous i_frame_vld and i_repeat: the frame wins and the repeat is ignored.
- i_frame_vld arriving during CHECK or EXEC: dropped, o_err_cnt+1.
- i_repeat in IDLE, CHECK or EXEC: ignored.
- Saturation: o_err_cnt holds at 255; the repeat count saturates at RPT_START.
- The ms tick counter free-runs, wrapping at TICK_DIV-1. Timeout tolerance is therefore −1 ms.
- o_dp is registered and recomputed every cycle.
- Reset mid-operation: everything returns to reset values immediately; no partial frame is retained.

Optional Feature:
IR_ADDR_FILTER_EN
- Defined: CHECK additionally requires addr == ADDR and addr == ~addrb. A mismatch counts as an error.
- Undefined: the address bytes are ignored and only the command complement check applies.

Decomposition:
- Shared package ir_pkg holds:
  - state encoding (2-bit: IDLE, CHECK, EXEC, HOLD)
  - key code constants (KEY_CLR = 10, KEY_BS = 11, KEY_ENT = 12, KEY_NONE = 15)
  - the NEC command byte constants
- One sub-module, ir_key_map: combinational cmd byte → {valid, 4-bit key}.
- Tick generation and the timeout counter stay inline.

Test Plan:
- Frame 0x00FF0CF3 (key 1), then 0x00FF18E7 (key 2) → o_digits = 24'h000012, o_key_vld pulses at t+3 each, o_dp = 6'b000001.
- Continuing: frame 0x00FF40BF (ENT) → o_value = 24'h000012, o_commit and o_key_vld pulse together, o_dp = 0, o_key = 12.
- Frame 0x00FF0CF2 (bad complement) → no o_key_vld, o_digits unchanged, o_err_cnt = 1. A second frame strobe during CHECK → o_err_cnt = 2.
- BS frame, then 5 repeats spaced 108 ms (cycles at TICK_DIV = 50) → 1 + 3 executions (repeats 3, 4, 5). Then no repeat for 120 ms → state IDLE; a further repeat has no effect.
- Seven digit entries 1..7 → o_digits = 24'h234567 (wrap-around drop). Then CLR → 0, held CLR repeats produce no extra o_key_vld.
- With IR_ADDR_FILTER_EN defined and ADDR = 8'h00: frame 0x01FE0CF3 → rejected, o_err_cnt+1. Without the macro the same frame → digit 1 accepted.
